// File: rtl/pift_pkg.sv
// Shared types for the PIFT taint collector: change-record layout and flag positions.
package pift_pkg;
  localparam int FLAG_FIRST = 0;
  localparam int FLAG_DROP  = 1;
  localparam int FLAG_W     = 2;
  localparam int DROP_CNT_W = 16;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_TS_W   = 32;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] total;
    logic [DEF_TS_W-1:0]  cycle;
    logic [FLAG_W-1:0]    flags;
  } taint_rec_t;
endpackage

// File: rtl/taint_rec_fifo.sv
// Synchronous record FIFO; head is only meaningful while !empty, otherwise the last
// popped record is presented so the consumer-side view holds steady.
module taint_rec_fifo
  import pift_pkg::*;
#(
  parameter type T     = taint_rec_t,
  parameter int  DEPTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  T               held;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           wr, rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign head  = empty ? held : mem[rd_ptr];

  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= push_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      held   <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) begin
        rd_ptr <= rd_ptr + AW'(1);
        held   <= mem[rd_ptr];
      end
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/taint_sum_monitor.sv
// Reduces per-cell taint bits and memory counts to a saturating, time-stamped global
// total and logs each change of that total into a record FIFO.
module taint_sum_monitor
  import pift_pkg::*;
#(
  parameter int N_DFF      = 64,
  parameter int N_MEM      = 4,
  parameter int MEM_CNT_W  = 11,
  parameter int CNT_W      = 16,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_DFF-1:0]           dff_taint_sum,
  input  logic [N_MEM*MEM_CNT_W-1:0] mem_taint_sum,
  output logic [CNT_W-1:0]           total_taint,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [CNT_W-1:0]           rec_total,
  output logic [TS_W-1:0]            rec_cycle,
  output logic [FLAG_W-1:0]          rec_flags,
  output logic [DROP_CNT_W-1:0]      drop_cnt,
  output logic                       first_taint_seen,
  output logic [TS_W-1:0]            first_taint_cycle
);
  localparam int POP_W  = $clog2(N_DFF + 1);
  localparam int MSUM_W = MEM_CNT_W + $clog2(N_MEM + 1);
  localparam int SUM_W  = ((POP_W > MSUM_W) ? POP_W : MSUM_W) + 1;
  localparam int EXT_W  = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + 1;

  typedef struct packed {
    logic [CNT_W-1:0]  total;
    logic [TS_W-1:0]   cycle;
    logic [FLAG_W-1:0] flags;
  } rec_t;

  logic [TS_W-1:0]            cyc, stamp1, stamp2;
  logic [N_DFF-1:0]           dff_clean;
  logic [N_MEM*MEM_CNT_W-1:0] mem_clean;
  logic [POP_W-1:0]           pop_c, pop1;
  logic [MSUM_W-1:0]          msum_c, msum1;
  logic [EXT_W-1:0]           sum_ext;
  logic [CNT_W-1:0]           total_next, last_rec;
  logic                       v1, v2, en, rdy, drop_pend;
  logic                       chg, first_hit, pop, do_push, full, empty;
  rec_t                       rec_in, head;

  // Case-equality maps X/Z to 0 so unknowns never reach the total.
  assign en  = (enable === 1'b1);
  assign rdy = (rec_ready === 1'b1);

  always_comb begin
    dff_clean = '0;
    mem_clean = '0;
    pop_c     = '0;
    msum_c    = '0;
    for (int i = 0; i < N_DFF; i++) begin
      dff_clean[i] = (dff_taint_sum[i] === 1'b1);
      pop_c        = pop_c + POP_W'(dff_clean[i]);
    end
    for (int i = 0; i < N_MEM*MEM_CNT_W; i++)
      mem_clean[i] = (mem_taint_sum[i] === 1'b1);
    for (int j = 0; j < N_MEM; j++)
      msum_c = msum_c + MSUM_W'(mem_clean[j*MEM_CNT_W +: MEM_CNT_W]);
  end

  assign sum_ext    = EXT_W'(pop1) + EXT_W'(msum1);
  assign total_next = (sum_ext > EXT_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum_ext[CNT_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc         <= '0;
      v1          <= 1'b0;
      pop1        <= '0;
      msum1       <= '0;
      stamp1      <= '0;
      v2          <= 1'b0;
      stamp2      <= '0;
      total_taint <= '0;
    end else begin
      cyc <= cyc + TS_W'(1);
      v1  <= en;
      if (en) begin
        pop1   <= pop_c;
        msum1  <= msum_c;
        stamp1 <= cyc;
      end
      v2 <= v1;
      if (v1) begin
        total_taint <= total_next;
        stamp2      <= stamp1;
      end
    end
  end

  assign chg       = v2 && (total_taint != last_rec);
  assign first_hit = chg && (last_rec == '0) && !first_taint_seen;
  assign pop       = rec_valid && rdy;
  assign do_push   = chg && (!full || pop);

  always_comb begin
    rec_in                   = '0;
    rec_in.total             = total_taint;
    rec_in.cycle             = stamp2;
    rec_in.flags[FLAG_FIRST] = first_hit;
    rec_in.flags[FLAG_DROP]  = drop_pend;
  end

  // last_rec tracks the latest change even when its record is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_rec          <= '0;
      drop_pend         <= 1'b0;
      drop_cnt          <= '0;
      first_taint_seen  <= 1'b0;
      first_taint_cycle <= '0;
    end else if (chg) begin
      last_rec <= total_taint;
      if (first_hit) begin
        first_taint_seen  <= 1'b1;
        first_taint_cycle <= stamp2;
      end
      if (do_push) drop_pend <= 1'b0;
      else begin
        drop_pend <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  taint_rec_fifo #(.T(rec_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (do_push),
    .push_data (rec_in),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign rec_valid = !empty;
  assign rec_total = head.total;
  assign rec_cycle = head.cycle;
  assign rec_flags = head.flags;
endmodule

// File: tb/tb_taint_sum_monitor.sv
// Bench for taint_sum_monitor: vector table, hand corner sequences and random traffic
// against a queue-based reference model; a CNT_W=8 instance covers saturation.
module tb_taint_sum_monitor;
  localparam int N_MEM = 4;
  localparam int MCW   = 11;
  localparam int DEPTH = 8;

  logic                 clock = 1'b0, reset = 1'b1, enable = 1'b0, rec_ready = 1'b0;
  logic [63:0]          dff_taint_sum = '0;
  logic [N_MEM*MCW-1:0] mem_taint_sum = '0;
  logic [15:0]          total_taint, rec_total, drop_cnt;
  logic                 rec_valid, first_taint_seen;
  logic [31:0]          rec_cycle, first_taint_cycle;
  logic [1:0]           rec_flags;
  logic [7:0]           s_total, s_rec_total;
  logic                 s_rec_valid, s_first;
  logic [31:0]          s_rec_cycle, s_first_cycle;
  logic [1:0]           s_rec_flags;
  logic [15:0]          s_drop;

  always #5 clock = ~clock;

  taint_sum_monitor dut (
    .clock(clock), .reset(reset), .enable(enable),
    .dff_taint_sum(dff_taint_sum), .mem_taint_sum(mem_taint_sum),
    .total_taint(total_taint), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_total(rec_total), .rec_cycle(rec_cycle), .rec_flags(rec_flags),
    .drop_cnt(drop_cnt), .first_taint_seen(first_taint_seen),
    .first_taint_cycle(first_taint_cycle)
  );

  taint_sum_monitor #(.CNT_W(8)) dut8 (
    .clock(clock), .reset(reset), .enable(enable),
    .dff_taint_sum(dff_taint_sum), .mem_taint_sum(mem_taint_sum),
    .total_taint(s_total), .rec_valid(s_rec_valid), .rec_ready(rec_ready),
    .rec_total(s_rec_total), .rec_cycle(s_rec_cycle), .rec_flags(s_rec_flags),
    .drop_cnt(s_drop), .first_taint_seen(s_first),
    .first_taint_cycle(s_first_cycle)
  );

  typedef struct {
    logic [15:0] total;
    logic [31:0] cycle;
    logic [1:0]  flags;
  } rec_m_t;

  typedef struct {
    bit          en;
    int unsigned sum;
    logic [31:0] stamp;
  } samp_t;

  typedef struct {
    logic [63:0] dff;
    int          m0, m1, m2, m3;
    int unsigned exp16, exp8;
  } vec_t;

  int          checks = 0, failures = 0;
  rec_m_t      q[$];
  rec_m_t      popped[$];
  rec_m_t      shown;
  samp_t       h0, h1;
  int unsigned m_total, m_total8, m_last, m_drop;
  bit          m_first, m_pend;
  logic [31:0] m_first_cyc, m_cyc;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned in_sum();
    int unsigned s;
    s = $countones(dff_taint_sum);
    for (int i = 0; i < N_MEM; i++) s += int'(mem_taint_sum[i*MCW +: MCW]);
    return s;
  endfunction

  function automatic logic [N_MEM*MCW-1:0] pack_mem(input int a, input int b, input int c, input int d);
    return {11'(d), 11'(c), 11'(b), 11'(a)};
  endfunction

  task automatic model_reset();
    q.delete();
    shown = '{16'd0, 32'd0, 2'd0};
    h0 = '{1'b0, 0, 32'd0};
    h1 = h0;
    m_total = 0; m_total8 = 0; m_last = 0; m_drop = 0;
    m_first = 1'b0; m_pend = 1'b0; m_first_cyc = '0; m_cyc = '0;
  endtask

  // One rising edge of the reference: pop, change-log of the total produced two edges
  // ago, total update from the previous sample, then capture of this edge's sample.
  task automatic model_edge();
    bit     pop, full;
    rec_m_t r;
    pop  = (q.size() > 0) && rec_ready;
    full = (q.size() == DEPTH);
    if (pop) shown = q.pop_front();
    if (h1.en && m_total != m_last) begin
      r.total = 16'(m_total);
      r.cycle = h1.stamp;
      r.flags = {m_pend, (m_last == 0 && !m_first)};
      if (r.flags[0]) begin
        m_first = 1'b1;
        m_first_cyc = h1.stamp;
      end
      m_last = m_total;
      if (full && !pop) begin
        m_pend = 1'b1;
        if (m_drop < 65535) m_drop++;
      end else begin
        q.push_back(r);
        m_pend = 1'b0;
      end
    end
    if (h0.en) begin
      m_total  = (h0.sum > 65535) ? 65535 : h0.sum;
      m_total8 = (h0.sum > 255) ? 255 : h0.sum;
    end
    h1 = h0;
    h0 = '{enable, in_sum(), m_cyc};
    m_cyc++;
  endtask

  task automatic check_all();
    rec_m_t e;
    e = (q.size() > 0) ? q[0] : shown;
    chk("total_taint", total_taint, m_total);
    chk("total_taint_w8", s_total, m_total8);
    chk("rec_valid", rec_valid, q.size() > 0);
    chk("rec_total", rec_total, e.total);
    chk("rec_cycle", rec_cycle, e.cycle);
    chk("rec_flags", rec_flags, e.flags);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("first_taint_seen", first_taint_seen, m_first);
    chk("first_taint_cycle", first_taint_cycle, m_first_cyc);
    chk("first_taint_seen_w8", s_first, m_first);
  endtask

  task automatic tick();
    if (rec_valid && rec_ready) popped.push_back('{rec_total, rec_cycle, rec_flags});
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{64'h0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{64'h5, 3, 0, 0, 0, 5, 5};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 2047, 2047, 2047, 2047, 8252, 255};
    tbl[3] = '{64'hFF, 1, 2, 3, 4, 18, 18};
    tbl[4] = '{64'h8000_0000_0000_0001, 0, 0, 0, 100, 102, 102};
    tbl[5] = '{64'h0, 2047, 0, 0, 0, 2047, 255};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 64, 64};
    tbl[7] = '{64'h0, 100, 50, 0, 100, 250, 250};
    tbl[8] = '{64'h0, 100, 100, 50, 6, 256, 255};
    tbl[9] = '{64'hF0F0, 0, 0, 0, 0, 8, 8};

    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    chk("reset_total", total_taint, 0);
    chk("reset_rec_valid", rec_valid, 0);
    reset  = 1'b0;
    enable = 1'b1;

    // Quiet start, then a first taint event sampled at cycle 10.
    while (m_cyc != 10) tick();
    chk("idle_first_seen", first_taint_seen, 0);
    dff_taint_sum = 64'h5;
    mem_taint_sum = pack_mem(3, 0, 0, 0);
    repeat (20) tick();
    chk("first_rec_valid", rec_valid, 1);
    chk("first_rec_total", rec_total, 5);
    chk("first_rec_cycle", rec_cycle, 10);
    chk("first_rec_flags", rec_flags, 2'b01);
    chk("first_taint_cycle_10", first_taint_cycle, 10);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    chk("single_record_only", rec_valid, 0);

    // Vector table, each vector held two edges so the total reflects it.
    rec_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dff_taint_sum = tbl[i].dff;
      mem_taint_sum = pack_mem(tbl[i].m0, tbl[i].m1, tbl[i].m2, tbl[i].m3);
      tick();
      tick();
      chk("vec_total", total_taint, tbl[i].exp16);
      chk("vec_total_w8", s_total, tbl[i].exp8);
    end

    // Overflow: ten consecutive distinct totals into a stalled depth-8 FIFO.
    dff_taint_sum = '0;
    mem_taint_sum = '0;
    repeat (20) tick();
    chk("drained_before_drop", rec_valid, 0);
    popped.delete();
    rec_ready = 1'b0;
    for (int k = 20; k < 30; k++) begin
      dff_taint_sum = (64'd1 << k) - 64'd1;
      tick();
    end
    repeat (3) tick();
    chk("drop_cnt_two", drop_cnt, 2);
    chk("full_head_total", rec_total, 20);
    rec_ready = 1'b1;
    dff_taint_sum = (64'd1 << 40) - 64'd1;
    tick();
    dff_taint_sum = (64'd1 << 41) - 64'd1;
    repeat (20) tick();
    chk("popped_count", popped.size(), 10);
    if (popped.size() >= 10) begin
      chk("post_drop_total", popped[8].total, 40);
      chk("post_drop_flags", popped[8].flags, 2'b10);
      chk("next_rec_total", popped[9].total, 41);
      chk("next_rec_flags", popped[9].flags, 2'b00);
      chk("held_head_last", popped[7].total, 27);
    end

    // Reset with the pipeline busy and three records queued.
    rec_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      dff_taint_sum = (64'd1 << k) - 64'd1;
      tick();
    end
    chk("pre_reset_queued", q.size(), 3);
    #2 reset = 1'b1;
    #1;
    chk("rst_total", total_taint, 0);
    chk("rst_rec_valid", rec_valid, 0);
    chk("rst_rec_total", rec_total, 0);
    chk("rst_rec_cycle", rec_cycle, 0);
    chk("rst_rec_flags", rec_flags, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_first_seen", first_taint_seen, 0);
    chk("rst_first_cycle", first_taint_cycle, 0);
    chk("rst_total_w8", s_total, 0);
    model_reset();
    dff_taint_sum = '0;
    @(negedge clock);
    reset = 1'b0;
    repeat (5) tick();
    chk("no_rec_after_reset", rec_valid, 0);
    dff_taint_sum = 64'h1F;
    repeat (5) tick();
    chk("rec_after_reset_flags", rec_flags, 2'b01);

    // Random traffic with holds, enable gaps, and phases of heavy back-pressure.
    for (int n = 0; n < 600; n++) begin
      enable    = ($urandom_range(0, 9) != 0);
      rec_ready = (n < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) begin
        dff_taint_sum = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: mem_taint_sum = '0;
          1: mem_taint_sum = pack_mem($urandom_range(0, 3), 0, $urandom_range(0, 3), 0);
          2: mem_taint_sum = pack_mem($urandom_range(0, 2047), $urandom_range(0, 2047),
                                      $urandom_range(0, 2047), $urandom_range(0, 2047));
          default: mem_taint_sum = pack_mem($urandom_range(0, 200), $urandom_range(0, 50), 0, 0);
        endcase
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/taint_sum_monitor.md
Name: taint_sum_monitor

Overview:
- Downstream collector for the PIFT taint cells in simulation. It consumes the per-register `taint_sum` bits from every instrumented dff cell and the per-memory tainted-word counts from every memory cell.
- It reduces them through a 2-stage pipeline to one global taint total, which is time-stamped.
- When the total changes, it pushes a change record into a small FIFO. The testbench logger drains the FIFO over a valid/ready port.
- It sits beside the SoC top and is driven by the same clock and reset.

Parameters:
- N_DFF, 64, number of dff-cell taint_sum inputs (1 bit each)
- N_MEM, 4, number of memory-cell taint_sum inputs
- MEM_CNT_W, 11, width of each memory taint_sum (ABITS+1 of the largest memory)
- CNT_W, 16, width of the global total; saturating
- TS_W, 32, cycle timestamp width; wraps
- FIFO_DEPTH, 8, record FIFO depth; power of two, ≥2

Ports:
- clock, input, 1, sole clock; all state updates on its rising edge
- reset, input, 1, asynchronous, active-high; clears all state
- enable, input, 1, sampling enable; inputs are captured only while high
- dff_taint_sum, input, N_DFF, one bit per dff taint cell
- mem_taint_sum, input, N_MEM*MEM_CNT_W, packed tainted-word counts; memory i occupies [i*MEM_CNT_W +: MEM_CNT_W]
- total_taint, output, CNT_W, current registered global total
- rec_valid, output, 1, FIFO head valid
- rec_ready, input, 1, consumer accepts head
- rec_total, output, CNT_W, head record total
- rec_cycle, output, TS_W, head record timestamp
- rec_flags, output, 2, head record flags: bit0 = first-nonzero, bit1 = records dropped before this one
- drop_cnt, output, 16, saturating count of records dropped on full
- first_taint_seen, output, 1, sticky; set when total first becomes nonzero
- first_taint_cycle, output, TS_W, timestamp of that event

Behaviour:
- Reset values:
  - All outputs are 0.
  - FIFO is empty.
  - Cycle counter, pipeline valids, last-recorded total and drop-pending flag are 0.
- Cycle counter:
  - Increments every clock out of reset, independent of enable.
  - Wraps at 2^TS_W.
- Stage 1, on the edge where enable=1:
  - Register popcount(dff_taint_sum).
  - Register the sum of all N_MEM counts, each zero-extended.
  - Register the current cycle counter as the stamp.
  - Set v1=1.
  - When enable=0, v1=0.
- Stage 2, when v1=1:
  - total = pop + memsum.
  - If the true sum exceeds 2^CNT_W-1, clamp total to 2^CNT_W-1.
  - Register total into total_taint and carry the stamp forward.
  - Set v2=1.
  - total_taint holds its value while v1=0.
- Latency: inputs sampled at edge k appear on total_taint after edge k+1 (2 cycles).
- Change detect, when v2=1:
  - If total_taint ≠ last_rec, push record {total_taint, stamp, flags} and set last_rec=total_taint.
  - Equal totals push nothing.
- Flag bit0: set when last_rec==0 and the new total ≠ 0, and first_taint_seen=0. On that cycle, first_taint_seen and first_taint_cycle are latched. Both are sticky until reset.
- Flag bit1: set to the drop-pending state. Drop-pending clears on a successful push.
- FIFO full with a push and no pop:
  - The record is dropped; last_rec is still updated.
  - drop_cnt increments, saturating at 0xFFFF.
  - Drop-pending is set.
- FIFO full with push and pop in the same cycle: both occur; no drop.
- FIFO empty: rec_valid=0 and rec_* hold their last values. A push into an empty FIFO appears on rec_valid the next cycle, with no fall-through.
- Pop happens when rec_valid & rec_ready.
- reset asserted mid-operation:
  - Clears everything asynchronously.
  - In-flight pipeline data is discarded.
  - No record is emitted on release.
- X on any input: that input is treated as 0 before summation, so X never reaches total_taint.

Decomposition:
- Package pift_pkg:
  - typedef taint_rec_t {total, cycle, flags}
  - localparams for the flag bit indices and DROP_CNT_W=16
- Sub-module taint_rec_fifo: parameterised synchronous FIFO of taint_rec_t with async active-high reset.
  - Inputs: push/full, pop/empty.
  - The FIFO has no drop logic; the monitor owns drop handling.

Test Plan:
- Reset release, enable=1, all inputs 0 → total_taint=0 forever, rec_valid=0, first_taint_seen=0.
- dff_taint_sum=0x5 and mem count[0]=3 applied at cycle 10 → total_taint=5 after 2 edges; one record {5, stamp 10, flags=01}; first_taint_cycle=10.
- Same inputs held for 20 cycles → exactly one record in total; no further pushes.
- rec_ready=0 while 10 distinct totals change on consecutive cycles (depth 8) → 8 records held, drop_cnt=2. Then rec_ready=1 and one more change → the 9th accepted record has flags bit1=1; the next record has bit1=0.
- All dff bits 1 and every mem count = 2^11-1, with CNT_W=8 → total_taint saturates at 255.
- reset asserted for 1 cycle while v1/v2 valid and FIFO holds 3 records → all outputs 0 immediately; after release no record appears until the total changes from 0.
